// File: rtl/ctrl_stage_pipe_pkg.sv
// Shared types and constants for the control-stage pipeline.
// Contents: register/ALUOp widths, forwarding select codes, the per-stage
// control sub-bundles, the full ID->EX bundle, the bubble constant and the
// destination-register helper.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALUOP_W = 2;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic               alu_src;
        logic               extend_sel;
        logic               branch;
        logic               jump;
        logic [ALUOP_W-1:0] alu_op;
    } ex_ctrl_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    // Contents of the ID/EX register.
    typedef struct packed {
        ex_ctrl_t          ex;
        mem_ctrl_t         mem;
        wb_ctrl_t          wb;
        logic [REG_AW-1:0] wreg;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
    } ctrl_bundle_t;

    // Contents of the EX/MEM register.
    typedef struct packed {
        mem_ctrl_t         mem;
        wb_ctrl_t          wb;
        logic [REG_AW-1:0] wreg;
    } mem_stage_t;

    // Contents of the MEM/WB register.
    typedef struct packed {
        wb_ctrl_t          wb;
        logic [REG_AW-1:0] wreg;
    } wb_stage_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    // Non-writing instructions carry wreg=0 so a don't-care RegDst can never
    // create a false hazard or forward downstream.
    function automatic logic [REG_AW-1:0] dest_reg(
        input logic              reg_write,
        input logic              reg_dst,
        input logic [REG_AW-1:0] rt,
        input logic [REG_AW-1:0] rd
    );
        if (!reg_write) begin
            return REG_ZERO;
        end
        return reg_dst ? rd : rt;
    endfunction

endpackage

// File: rtl/ctrl_stage_pipe_if.sv
// Decoded-control interface between the ID stage and the control pipeline.
// master: ID-side driver (enable, flush, decoded control, register fields);
//         observes stage outputs, stall and forwarding selects.
// slave:  the pipeline (ctrl_stage_pipe).
interface ctrl_stage_pipe_if;
    import pipe_ctrl_pkg::*;

    logic               en_reg;
    logic               flush_id;

    logic               id_RegDst;
    logic               id_ALUSrc;
    logic               id_MemtoReg;
    logic               id_RegWrite;
    logic               id_MemRead;
    logic               id_MemWrite;
    logic               id_Branch;
    logic               id_Jump;
    logic               id_ExtendSel;
    logic [ALUOP_W-1:0] id_ALUOp;
    logic [REG_AW-1:0]  id_rs;
    logic [REG_AW-1:0]  id_rt;
    logic [REG_AW-1:0]  id_rd;

    logic               ex_ALUSrc;
    logic               ex_ExtendSel;
    logic               ex_Branch;
    logic               ex_Jump;
    logic [ALUOP_W-1:0] ex_ALUOp;
    logic [REG_AW-1:0]  ex_rs;
    logic [REG_AW-1:0]  ex_rt;

    logic               mem_MemRead;
    logic               mem_MemWrite;
    logic               mem_RegWrite;
    logic               mem_MemtoReg;
    logic [REG_AW-1:0]  mem_wreg;

    logic               wb_RegWrite;
    logic               wb_MemtoReg;
    logic [REG_AW-1:0]  wb_wreg;

    logic               load_use_stall;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;

    modport master (
        output en_reg, flush_id,
        output id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
        output id_MemWrite, id_Branch, id_Jump, id_ExtendSel, id_ALUOp,
        output id_rs, id_rt, id_rd,
        input  ex_ALUSrc, ex_ExtendSel, ex_Branch, ex_Jump, ex_ALUOp, ex_rs, ex_rt,
        input  mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg, mem_wreg,
        input  wb_RegWrite, wb_MemtoReg, wb_wreg,
        input  load_use_stall, fwd_a, fwd_b
    );

    modport slave (
        input  en_reg, flush_id,
        input  id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
        input  id_MemWrite, id_Branch, id_Jump, id_ExtendSel, id_ALUOp,
        input  id_rs, id_rt, id_rd,
        output ex_ALUSrc, ex_ExtendSel, ex_Branch, ex_Jump, ex_ALUOp, ex_rs, ex_rt,
        output mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg, mem_wreg,
        output wb_RegWrite, wb_MemtoReg, wb_wreg,
        output load_use_stall, fwd_a, fwd_b
    );

endinterface

// File: rtl/ctrl_stage_pipe_fwd_sel.sv
// Single-operand forwarding select.
// i_src:                   EX-stage source register number
// i_mem_reg_write/i_mem_wreg: MEM-stage write enable and destination
// i_wb_reg_write/i_wb_wreg:   WB-stage write enable and destination
// o_sel:                   FWD_MEM, FWD_WB or FWD_NONE (MEM wins over WB)
module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_mem_reg_write,
    input  logic [REG_AW-1:0] i_mem_wreg,
    input  logic              i_wb_reg_write,
    input  logic [REG_AW-1:0] i_wb_wreg,
    output logic [1:0]        o_sel
);

    always_comb begin
        o_sel = FWD_NONE;
        if (i_mem_reg_write && (i_mem_wreg != REG_ZERO) && (i_mem_wreg == i_src)) begin
            o_sel = FWD_MEM;
        end else if (i_wb_reg_write && (i_wb_wreg != REG_ZERO) && (i_wb_wreg == i_src)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ctrl_stage_pipe.sv
// Control pipeline for the EX, MEM and WB stages of the MIPS core.
// i_clk:   rising-edge clock
// i_rst_n: asynchronous active-low reset, clears every stage
// pipe_if: slave side of the decoded-control interface; carries enable, flush,
//          ID-stage control/register fields in and stage control, load-use
//          stall and operand forwarding selects out.
module ctrl_stage_pipe
    import pipe_ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    ctrl_stage_pipe_if.slave   pipe_if
);

    ctrl_bundle_t r_ex;
    mem_stage_t   r_mem;
    wb_stage_t    r_wb;

    ctrl_bundle_t w_id_bundle;
    ctrl_bundle_t w_ex_d;
    logic         w_load_use;
    logic [1:0]   w_fwd_a;
    logic [1:0]   w_fwd_b;

    always_comb begin
        w_id_bundle                = BUBBLE;
        w_id_bundle.ex.alu_src     = pipe_if.id_ALUSrc;
        w_id_bundle.ex.extend_sel  = pipe_if.id_ExtendSel;
        w_id_bundle.ex.branch      = pipe_if.id_Branch;
        w_id_bundle.ex.jump        = pipe_if.id_Jump;
        w_id_bundle.ex.alu_op      = pipe_if.id_ALUOp;
        w_id_bundle.mem.mem_read   = pipe_if.id_MemRead;
        w_id_bundle.mem.mem_write  = pipe_if.id_MemWrite;
        w_id_bundle.wb.reg_write   = pipe_if.id_RegWrite;
        w_id_bundle.wb.mem_to_reg  = pipe_if.id_MemtoReg;
        w_id_bundle.wreg           = dest_reg(pipe_if.id_RegWrite, pipe_if.id_RegDst,
                                              pipe_if.id_rt, pipe_if.id_rd);
        w_id_bundle.rs             = pipe_if.id_rs;
        w_id_bundle.rt             = pipe_if.id_rt;
    end

    // A load in EX whose result an ID operand needs; the bubble it causes
    // clears ex mem_read, so the stall lasts exactly one enabled cycle.
    assign w_load_use = r_ex.mem.mem_read && (r_ex.wreg != REG_ZERO) &&
                        ((r_ex.wreg == pipe_if.id_rs) || (r_ex.wreg == pipe_if.id_rt));

    always_comb begin
        w_ex_d = w_id_bundle;
        if (w_load_use || pipe_if.flush_id) begin
            w_ex_d = BUBBLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex  <= BUBBLE;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (pipe_if.en_reg) begin
            r_ex       <= w_ex_d;
            r_mem.mem  <= r_ex.mem;
            r_mem.wb   <= r_ex.wb;
            r_mem.wreg <= r_ex.wreg;
            r_wb.wb    <= r_mem.wb;
            r_wb.wreg  <= r_mem.wreg;
        end
    end

    pipe_fwd_sel u_fwd_a (
        .i_src          (r_ex.rs),
        .i_mem_reg_write(r_mem.wb.reg_write),
        .i_mem_wreg     (r_mem.wreg),
        .i_wb_reg_write (r_wb.wb.reg_write),
        .i_wb_wreg      (r_wb.wreg),
        .o_sel          (w_fwd_a)
    );

    pipe_fwd_sel u_fwd_b (
        .i_src          (r_ex.rt),
        .i_mem_reg_write(r_mem.wb.reg_write),
        .i_mem_wreg     (r_mem.wreg),
        .i_wb_reg_write (r_wb.wb.reg_write),
        .i_wb_wreg      (r_wb.wreg),
        .o_sel          (w_fwd_b)
    );

    assign pipe_if.ex_ALUSrc      = r_ex.ex.alu_src;
    assign pipe_if.ex_ExtendSel   = r_ex.ex.extend_sel;
    assign pipe_if.ex_Branch      = r_ex.ex.branch;
    assign pipe_if.ex_Jump        = r_ex.ex.jump;
    assign pipe_if.ex_ALUOp       = r_ex.ex.alu_op;
    assign pipe_if.ex_rs          = r_ex.rs;
    assign pipe_if.ex_rt          = r_ex.rt;

    assign pipe_if.mem_MemRead    = r_mem.mem.mem_read;
    assign pipe_if.mem_MemWrite   = r_mem.mem.mem_write;
    assign pipe_if.mem_RegWrite   = r_mem.wb.reg_write;
    assign pipe_if.mem_MemtoReg   = r_mem.wb.mem_to_reg;
    assign pipe_if.mem_wreg       = r_mem.wreg;

    assign pipe_if.wb_RegWrite    = r_wb.wb.reg_write;
    assign pipe_if.wb_MemtoReg    = r_wb.wb.mem_to_reg;
    assign pipe_if.wb_wreg        = r_wb.wreg;

    assign pipe_if.load_use_stall = w_load_use;
    assign pipe_if.fwd_a          = w_fwd_a;
    assign pipe_if.fwd_b          = w_fwd_b;

endmodule
